// File: rtl/multicycle_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_pkg
// Shared types and constants for the multicycle controller: the FSM state
// encoding, instruction-class codes, ALU function codes and the width of the
// EXECUTE-cycle counter.
// -----------------------------------------------------------------------------
package multicycle_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_BRANCH    = 3'd5
  } state_t;

  // Instruction classes (op field)
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_LDR = 2'b01;
  localparam logic [1:0] OP_STR = 2'b10;
  localparam logic [1:0] OP_B   = 2'b11;

  // ALU function codes (func field) that change control flow
  localparam logic [3:0] FUNC_CMP = 4'b1001;
  localparam logic [3:0] FUNC_MUL = 4'b0010;

  // EXECUTE-cycle counter width; covers MUL_CYCLES up to 15
  localparam int CNT_W = 4;

endpackage

// File: rtl/mc_exec_counter.sv
// -----------------------------------------------------------------------------
// mc_exec_counter
// Counts cycles spent in EXECUTE so a multicycle MUL knows when it is on its
// final cycle. Held at zero while i_clear is high, so every entry into
// EXECUTE starts from zero. Saturates at all-ones rather than wrapping.
//
// Ports
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset
//   i_clear  : force count to zero
//   i_en     : advance count by one
//   o_count  : current count
// -----------------------------------------------------------------------------
module mc_exec_counter
  import multicycle_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM for a multicycle processor datapath:
// FETCH -> DECODE -> (EXECUTE | BRANCH) -> (MEMORY | WRITEBACK | FETCH).
// All outputs are decoded combinationally from the current state (and
// mem_ready where a memory handshake completes).
//
// Configuration macro: MUL_MULTICYCLE_EN
//   defined   : MUL spends MUL_CYCLES cycles in EXECUTE, alu_busy active,
//               mc_exec_counter instantiated.
//   undefined : every instruction spends one cycle in EXECUTE, alu_busy = 0.
//
// Parameters
//   MUL_CYCLES : EXECUTE cycles for MUL when the macro is defined (2..15)
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   op, func   : instruction class / ALU function, captured in DECODE
//   mem_ready  : memory completion, only observed while mem_req = 1
//   mem_req    : memory access request (FETCH, MEMORY)
//   adr_src    : address select, 0 = PC, 1 = ALU result
//   ir_write, pc_write, reg_write, mem_write, flag_w : datapath enables
//   alu_busy   : high on every EXECUTE cycle except the last
//   state_o    : current state code, for debug
// -----------------------------------------------------------------------------
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [3:0] func,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       flag_w,
  output logic       alu_busy,
  output logic [2:0] state_o
);

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_op;
  logic [3:0] r_func;
  logic       w_is_cmp;
  logic       w_exec_last;

  // State register and instruction capture. op/func are only sampled in
  // DECODE, so they are ignored everywhere else.
  // NOTE: reset is synchronous here: it is evaluated inside the clocked block
  // and wins over every transition on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_op    <= OP_DP;
      r_func  <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) begin
        r_op   <= op;
        r_func <= func;
      end
    end
  end

  assign w_is_cmp = (r_op == OP_DP) && (r_func == FUNC_CMP);

`ifdef MUL_MULTICYCLE_EN
  logic             w_is_mul;
  logic [CNT_W-1:0] w_count;

  assign w_is_mul = (r_op == OP_DP) && (r_func == FUNC_MUL);

  // Counter sits at zero outside EXECUTE, so it is clear on every entry.
  mc_exec_counter u_exec_counter (
    .clk     (clk),
    .reset   (reset),
    .i_clear (r_state != S_EXECUTE),
    .i_en    (r_state == S_EXECUTE),
    .o_count (w_count)
  );

  assign w_exec_last = !w_is_mul || (w_count == CNT_W'(MUL_CYCLES - 1));
  assign alu_busy    = (r_state == S_EXECUTE) && !w_exec_last;
`else
  // Single-cycle EXECUTE for everything; MUL_CYCLES has no effect.
  logic [31:0] w_unused_mul_cycles;
  assign w_unused_mul_cycles = MUL_CYCLES;
  assign w_exec_last         = 1'b1;
  assign alu_busy            = 1'b0;
`endif

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    mem_req      = 1'b0;
    adr_src      = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    mem_write    = 1'b0;
    flag_w       = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          w_next_state = S_DECODE;
        end
      end

      // Branch decision uses the live op; the same value is captured above.
      S_DECODE: begin
        w_next_state = (op == OP_B) ? S_BRANCH : S_EXECUTE;
      end

      S_EXECUTE: begin
        if (w_exec_last) begin
          case (r_op)
            OP_LDR, OP_STR: w_next_state = S_MEMORY;
            OP_DP: begin
              if (w_is_cmp) begin
                flag_w       = 1'b1;
                w_next_state = S_FETCH;
              end else begin
                w_next_state = S_WRITEBACK;
              end
            end
            default: w_next_state = S_FETCH;
          endcase
        end
      end

      S_MEMORY: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = (r_op == OP_STR);
        if (mem_ready) begin
          w_next_state = (r_op == OP_LDR) ? S_WRITEBACK : S_FETCH;
        end
      end

      S_WRITEBACK: begin
        reg_write    = 1'b1;
        w_next_state = S_FETCH;
      end

      S_BRANCH: begin
        pc_write     = 1'b1;
        w_next_state = S_FETCH;
      end

      // Unused codes 6 and 7 recover to FETCH.
      default: w_next_state = S_FETCH;
    endcase
  end

  assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl. Each scenario queues per-cycle
// stimulus {reset, mem_ready, op, func} together with the expected
// {state, mem_req, adr_src, ir_write, pc_write, reg_write, mem_write, flag_w,
// alu_busy}; the queued cycles are then applied on the falling edge and the
// outputs compared 1 ns later. Honours MUL_MULTICYCLE_EN like the design.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int MUL_CYCLES = 4;

  localparam logic [2:0] ST_F = 3'd0;
  localparam logic [2:0] ST_D = 3'd1;
  localparam logic [2:0] ST_E = 3'd2;
  localparam logic [2:0] ST_M = 3'd3;
  localparam logic [2:0] ST_W = 3'd4;
  localparam logic [2:0] ST_B = 3'd5;

  // Flag vectors: {mem_req, adr_src, ir_write, pc_write, reg_write,
  //                mem_write, flag_w, alu_busy}
  localparam logic [7:0] FL_NONE  = 8'b0000_0000;
  localparam logic [7:0] FL_FWAIT = 8'b1000_0000;
  localparam logic [7:0] FL_FDONE = 8'b1011_0000;
  localparam logic [7:0] FL_MLDR  = 8'b1100_0000;
  localparam logic [7:0] FL_MSTR  = 8'b1100_0100;
  localparam logic [7:0] FL_WB    = 8'b0000_1000;
  localparam logic [7:0] FL_BR    = 8'b0001_0000;
  localparam logic [7:0] FL_CMP   = 8'b0000_0010;
  localparam logic [7:0] FL_BUSY  = 8'b0000_0001;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [3:0] func;
  logic       mem_ready;
  logic       mem_req, adr_src, ir_write, pc_write, reg_write;
  logic       mem_write, flag_w, alu_busy;
  logic [2:0] state_o;

  logic [7:0]  stim_q[$];
  logic [10:0] exp_q[$];
  wire  [10:0] obs = {state_o, mem_req, adr_src, ir_write, pc_write,
                      reg_write, mem_write, flag_w, alu_busy};

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .func      (func),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .adr_src   (adr_src),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .reg_write (reg_write),
    .mem_write (mem_write),
    .flag_w    (flag_w),
    .alu_busy  (alu_busy),
    .state_o   (state_o)
  );

  // Queue one cycle of stimulus with the outputs expected during that cycle.
  function automatic void add(input logic rst, input logic mr,
                              input logic [1:0] o, input logic [3:0] f,
                              input logic [2:0] st, input logic [7:0] fl);
    stim_q.push_back({rst, mr, o, f});
    exp_q.push_back({st, fl});
  endfunction

  task automatic test_reset();
    logic [7:0] s; logic [10:0] e; int k = 0;
    add(0, 0, 2'b00, 4'h0, ST_F, FL_FWAIT);  // post-reset: waiting fetch
    add(0, 0, 2'b00, 4'h0, ST_F, FL_FWAIT);
    add(1, 1, 2'b00, 4'h0, ST_F, FL_FDONE);  // reset beats FETCH->DECODE
    add(0, 0, 2'b00, 4'h0, ST_F, FL_FWAIT);
    add(0, 1, 2'b00, 4'h0, ST_F, FL_FDONE);
    add(1, 1, 2'b11, 4'h0, ST_D, FL_NONE);   // reset beats DECODE->BRANCH
    add(0, 0, 2'b00, 4'h0, ST_F, FL_FWAIT);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk); {reset, mem_ready, op, func} = s; #1;
      n_cmp++;
      if (obs !== e) begin
        n_mis++;
        $display("FAIL reset cyc%0d: got st=%0d fl=%b, want st=%0d fl=%b",
                 k, obs[10:8], obs[7:0], e[10:8], e[7:0]);
      end
      k++;
    end
  endtask

  task automatic test_dp();
    logic [7:0] s; logic [10:0] e; int k = 0;
    add(0, 1, 2'b00, 4'h0, ST_F, FL_FDONE);
    add(0, 1, 2'b00, 4'h0, ST_D, FL_NONE);
    add(0, 1, 2'b00, 4'h0, ST_E, FL_NONE);
    add(0, 1, 2'b00, 4'h0, ST_W, FL_WB);
    // op/func outside DECODE must be ignored
    add(0, 1, 2'b11, 4'h9, ST_F, FL_FDONE);
    add(0, 1, 2'b00, 4'h0, ST_D, FL_NONE);
    add(0, 1, 2'b11, 4'h9, ST_E, FL_NONE);
    add(0, 1, 2'b01, 4'h9, ST_W, FL_WB);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk); {reset, mem_ready, op, func} = s; #1;
      n_cmp++;
      if (obs !== e) begin
        n_mis++;
        $display("FAIL dp cyc%0d: got st=%0d fl=%b, want st=%0d fl=%b",
                 k, obs[10:8], obs[7:0], e[10:8], e[7:0]);
      end
      k++;
    end
  endtask

  task automatic test_ldr();
    logic [7:0] s; logic [10:0] e; int k = 0;
    add(0, 0, 2'b00, 4'h0, ST_F, FL_FWAIT);  // fetch wait state
    add(0, 1, 2'b00, 4'h0, ST_F, FL_FDONE);
    add(0, 1, 2'b01, 4'h0, ST_D, FL_NONE);   // mem_ready high, mem_req low
    add(0, 1, 2'b00, 4'h0, ST_E, FL_NONE);
    add(0, 0, 2'b00, 4'h0, ST_M, FL_MLDR);
    add(0, 0, 2'b00, 4'h0, ST_M, FL_MLDR);
    add(0, 0, 2'b00, 4'h0, ST_M, FL_MLDR);
    add(0, 1, 2'b00, 4'h0, ST_M, FL_MLDR);
    add(0, 1, 2'b00, 4'h0, ST_W, FL_WB);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk); {reset, mem_ready, op, func} = s; #1;
      n_cmp++;
      if (obs !== e) begin
        n_mis++;
        $display("FAIL ldr cyc%0d: got st=%0d fl=%b, want st=%0d fl=%b",
                 k, obs[10:8], obs[7:0], e[10:8], e[7:0]);
      end
      k++;
    end
  endtask

  task automatic test_str_cmp_branch();
    logic [7:0] s; logic [10:0] e; int k = 0;
    // STR zero-wait: 4 cycles
    add(0, 1, 2'b00, 4'h0, ST_F, FL_FDONE);
    add(0, 1, 2'b10, 4'h0, ST_D, FL_NONE);
    add(0, 1, 2'b00, 4'h0, ST_E, FL_NONE);
    add(0, 1, 2'b00, 4'h0, ST_M, FL_MSTR);
    // CMP: 3 cycles, flag only, no register write
    add(0, 1, 2'b00, 4'h0, ST_F, FL_FDONE);
    add(0, 1, 2'b00, 4'h9, ST_D, FL_NONE);
    add(0, 1, 2'b00, 4'h0, ST_E, FL_CMP);
    // B: 3 cycles, pc_write in FETCH and BRANCH
    add(0, 1, 2'b00, 4'h0, ST_F, FL_FDONE);
    add(0, 1, 2'b11, 4'h0, ST_D, FL_NONE);
    add(0, 1, 2'b00, 4'h0, ST_B, FL_BR);
    add(0, 0, 2'b00, 4'h0, ST_F, FL_FWAIT);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk); {reset, mem_ready, op, func} = s; #1;
      n_cmp++;
      if (obs !== e) begin
        n_mis++;
        $display("FAIL str_cmp_b cyc%0d: got st=%0d fl=%b, want st=%0d fl=%b",
                 k, obs[10:8], obs[7:0], e[10:8], e[7:0]);
      end
      k++;
    end
  endtask

  task automatic test_mul();
    logic [7:0] s; logic [10:0] e; int k = 0;
    add(0, 1, 2'b00, 4'h0, ST_F, FL_FDONE);
    add(0, 1, 2'b00, 4'h2, ST_D, FL_NONE);
`ifdef MUL_MULTICYCLE_EN
    for (int i = 0; i < MUL_CYCLES; i++)
      add(0, 1, 2'b00, 4'h0, ST_E, (i < MUL_CYCLES - 1) ? FL_BUSY : FL_NONE);
`else
    add(0, 1, 2'b00, 4'h0, ST_E, FL_NONE);
`endif
    add(0, 1, 2'b00, 4'h0, ST_W, FL_WB);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk); {reset, mem_ready, op, func} = s; #1;
      n_cmp++;
      if (obs !== e) begin
        n_mis++;
        $display("FAIL mul cyc%0d: got st=%0d fl=%b, want st=%0d fl=%b",
                 k, obs[10:8], obs[7:0], e[10:8], e[7:0]);
      end
      k++;
    end
  endtask

  task automatic test_reset_midflight();
    logic [7:0] s; logic [10:0] e; int k = 0;
    // Reset during the second MEMORY wait cycle of a STR
    add(0, 1, 2'b00, 4'h0, ST_F, FL_FDONE);
    add(0, 1, 2'b10, 4'h0, ST_D, FL_NONE);
    add(0, 1, 2'b00, 4'h0, ST_E, FL_NONE);
    add(0, 0, 2'b00, 4'h0, ST_M, FL_MSTR);
    add(1, 0, 2'b00, 4'h0, ST_M, FL_MSTR);
    add(0, 0, 2'b00, 4'h0, ST_F, FL_FWAIT);
    // Reset in the middle of a MUL
    add(0, 1, 2'b00, 4'h0, ST_F, FL_FDONE);
    add(0, 1, 2'b00, 4'h2, ST_D, FL_NONE);
`ifdef MUL_MULTICYCLE_EN
    add(0, 1, 2'b00, 4'h0, ST_E, FL_BUSY);
    add(1, 1, 2'b00, 4'h0, ST_E, FL_BUSY);
`else
    add(1, 1, 2'b00, 4'h0, ST_E, FL_NONE);
`endif
    add(0, 0, 2'b00, 4'h0, ST_F, FL_FWAIT);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      @(negedge clk); {reset, mem_ready, op, func} = s; #1;
      n_cmp++;
      if (obs !== e) begin
        n_mis++;
        $display("FAIL reset_mid cyc%0d: got st=%0d fl=%b, want st=%0d fl=%b",
                 k, obs[10:8], obs[7:0], e[10:8], e[7:0]);
      end
      k++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    op        = 2'b00;
    func      = 4'h0;
    repeat (2) @(posedge clk);
    test_reset();
    test_dp();
    test_ldr();
    test_str_cmp_branch();
    test_mul();
    test_reset_midflight();
    test_mul();               // counter must start clean after the abort
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, default 4, number of EXECUTE cycles for a MUL instruction when MUL_MULTICYCLE_EN is defined; legal range 2..15.
REQ-002 Clock and reset SHALL be: one clock, reset synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 op  input  2  instruction class: 00 data-processing, 01 LDR, 10 STR, 11 B.
REQ-006 func  input  4  ALU function field; 1001 = CMP, 0010 = MUL.
REQ-007 mem_ready  input  1  memory completion, sampled on each rising edge while mem_req=1.
REQ-008 mem_req  output  1  memory access request, held high until mem_ready is sampled high.
REQ-009 adr_src  output  1  memory address select: 0 = PC, 1 = ALU result.
REQ-010 ir_write, pc_write, reg_write, mem_write, flag_w  output  1 each  datapath write enables.
REQ-011 alu_busy  output  1  high during every EXECUTE cycle except the last.
REQ-012 state_o  output  3  current state encoding, for debug.

Function
REQ-013 The FSM SHALL use states FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, BRANCH=5; codes 6 and 7 SHALL return to FETCH on the next edge.
REQ-014 FETCH: mem_req=1, adr_src=0; when mem_ready=1, ir_write=1 and pc_write=1 combinationally that cycle, then go to DECODE; otherwise stay in FETCH.
REQ-015 DECODE: op and func are registered; next state is BRANCH for op=11, otherwise EXECUTE.
REQ-016 EXECUTE: exits after one cycle, or after MUL_CYCLES cycles for MUL when MUL_MULTICYCLE_EN is defined. The exit target is: WRITEBACK for data-processing (non-CMP), FETCH for CMP, and MEMORY for LDR/STR.
REQ-017 CMP: flag_w=1 on the final EXECUTE cycle only; reg_write SHALL never assert for CMP.
REQ-018 MEMORY: mem_req=1 and adr_src=1; mem_write=1 for STR; hold the state until mem_ready=1. On mem_ready, LDR goes to WRITEBACK and STR goes to FETCH.
REQ-019 WRITEBACK: reg_write=1 for exactly one cycle, then go to FETCH.
REQ-020 BRANCH: pc_write=1 for exactly one cycle, then go to FETCH.
REQ-021 Zero-wait latencies SHALL be: B 3, CMP 3, data-processing 4, STR 4, LDR 5 cycles.
REQ-022 The EXECUTE cycle counter SHALL be 4 bits, cleared on entry to EXECUTE, with no wrap-around within a legal MUL_CYCLES.
REQ-023 If mem_ready is high while mem_req is low, it SHALL be ignored.
REQ-024 op and func SHALL be ignored outside DECODE.

Reset
REQ-025 When reset=1 at an edge, the next state SHALL be FETCH, the counter SHALL be cleared, and the registered op/func SHALL be cleared; this takes priority over every transition, including mid-MEMORY and mid-MUL.
REQ-026 During the first cycle after reset, mem_req=1, adr_src=0, and all write enables and alu_busy SHALL be 0 until mem_ready.

Configuration
REQ-027 When MUL_MULTICYCLE_EN is defined, MUL SHALL occupy MUL_CYCLES EXECUTE cycles and alu_busy is active; when it is undefined, every instruction SHALL use one EXECUTE cycle, alu_busy SHALL be tied to 0, and the counter SHALL be removed.

Structure
REQ-028 Package multicycle_pkg SHALL hold the state_t enum, the op class constants (OP_DP, OP_LDR, OP_STR, OP_B), and the func constants FUNC_MUL and FUNC_CMP.
REQ-029 One sub-module, mc_exec_counter, SHALL implement the EXECUTE-cycle counter and SHALL be instantiated only under MUL_MULTICYCLE_EN.

Verification
REQ-030 Reset, then mem_ready=1 constantly, op=00, func=0000 -> states 0,1,2,4,0; reg_write high in cycle 4 only.
REQ-031 op=01 LDR, mem_ready low for 3 MEMORY cycles -> MEMORY held for 4 cycles with mem_req=1 and adr_src=1, then WRITEBACK with reg_write=1 for one cycle.
REQ-032 op=00, func=1001 CMP -> flag_w=1 in EXECUTE, reg_write never asserted, back to FETCH after 3 cycles.
REQ-033 MUL with MUL_MULTICYCLE_EN and MUL_CYCLES=4 -> 4 EXECUTE cycles with alu_busy=1,1,1,0; without the macro, 1 EXECUTE cycle.
REQ-034 op=11 B -> pc_write=1 in FETCH and in BRANCH; total 3 cycles.
REQ-035 Reset asserted in the second MEMORY wait cycle of a STR -> mem_write=0 and state FETCH on the next cycle; no reg_write.
